// File: rtl/decision_function_hwf.sv
// decision_function_hwf: last stage of the HWF SVM classifier.
// Accumulates one signed coefficient times unsigned kernel term per strobe,
// then adds the bias and reports the sign of the decision value as the class.
// Optional feature macro: DECISION_SCORE_OUT_EN exposes the registered score acc+b.
//
// state  | meaning
// IDLE   | waiting for the first term of a decision
// ACCUM  | terms 1..NUM_OF_SV-1 being accepted, stalls while enable is low
// FINISH | bias added, class/done registered, accumulator cleared
module decision_function_hwf #(
  parameter int XLEN_PIXEL = 8,
  parameter int NUM_OF_SV  = 10
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  decision_funct_en,
  input  logic [2*XLEN_PIXEL*NUM_OF_SV-1:0]     kernel_out,
  input  logic [2*XLEN_PIXEL-1:0]               product,
  input  logic [2*XLEN_PIXEL-1:0]               b,
  output logic                                  y_class,
  output logic                                  done
`ifdef DECISION_SCORE_OUT_EN
  ,
  output logic signed [4*XLEN_PIXEL+$clog2(NUM_OF_SV)+1:0] score
`endif
);

  localparam int W  = 2*XLEN_PIXEL;
  localparam int PW = 4*XLEN_PIXEL + 1;
  localparam int AW = 4*XLEN_PIXEL + 1 + $clog2(NUM_OF_SV) + 1;
  localparam int IW = (NUM_OF_SV > 1) ? $clog2(NUM_OF_SV) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_OF_SV-1);

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;

  state_t          state, state_nxt;
  logic            accept, finish;
  logic [IW-1:0]   idx;
  logic [AW-1:0]   acc;
  logic [W-1:0]    kernel_sel;
  logic [PW-1:0]   prod_x, kern_x, term;
  logic [AW-1:0]   acc_nxt, f_sum;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and term-acceptance decode; FINISH never consumes a term
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (decision_funct_en) begin
          accept    = 1'b1;
          state_nxt = (idx == LAST_IDX) ? FINISH : ACCUM;
        end
      end
      ACCUM: begin
        if (decision_funct_en) begin
          accept = 1'b1;
          if (idx == LAST_IDX) state_nxt = FINISH;
        end
      end
      FINISH: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Select the kernel slice for the current support vector
  always_comb begin
    kernel_sel = '0;
    for (int k = 0; k < NUM_OF_SV; k++) begin
      if (idx == IW'(k)) kernel_sel = kernel_out[k*W +: W];
    end
  end

  // Signed coefficient times zero-extended kernel; both operands widened first
  // so the multiply is exact and the accumulator can never overflow
  always_comb begin
    prod_x  = {{(PW-W){product[W-1]}}, product};
    kern_x  = {{(PW-W){1'b0}}, kernel_sel};
    term    = prod_x * kern_x;
    acc_nxt = acc + {{(AW-PW){term[PW-1]}}, term};
    f_sum   = acc + {{(AW-W){b[W-1]}}, b};
  end

  // Accumulator, term index and registered decision outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc     <= '0;
      idx     <= '0;
      y_class <= 1'b0;
      done    <= 1'b0;
`ifdef DECISION_SCORE_OUT_EN
      score   <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        acc <= acc_nxt;
        idx <= idx + IW'(1);
      end else if (finish) begin
        acc     <= '0;
        idx     <= '0;
        y_class <= ~f_sum[AW-1];
        done    <= 1'b1;
`ifdef DECISION_SCORE_OUT_EN
        score   <= f_sum;
`endif
      end
    end
  end

endmodule

// File: tb/tb_decision_function_hwf.sv
// Randomised scoreboard bench for decision_function_hwf.
module tb_decision_function_hwf;

  localparam int XLEN = 8;
  localparam int NSV  = 10;
  localparam int W    = 2*XLEN;
  localparam int SW   = 4*XLEN + $clog2(NSV) + 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 en  = 1'b0;
  logic [W*NSV-1:0]     kernel_out = '0;
  logic [W-1:0]         product = '0;
  logic [W-1:0]         b = '0;
  logic                 y_class;
  logic                 done;
`ifdef DECISION_SCORE_OUT_EN
  logic signed [SW-1:0] score;
`endif

  decision_function_hwf #(.XLEN_PIXEL(XLEN), .NUM_OF_SV(NSV)) dut (
    .clk               (clk),
    .rst               (rst),
    .decision_funct_en (en),
    .kernel_out        (kernel_out),
    .product           (product),
    .b                 (b),
    .y_class           (y_class),
    .done              (done)
`ifdef DECISION_SCORE_OUT_EN
    ,
    .score             (score)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit     y;
    longint f;
    int     cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  logic [W-1:0]        kern [NSV];
  logic signed [W-1:0] prod [NSV];
  logic signed [W-1:0] bias;

  // Monitor: every done pulse is matched against the oldest expected decision
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && done) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          tests++;
          if (y_class !== e.y) begin
            fails++;
            $display("FAIL y_class f=%0d got %0b want %0b", e.f, y_class, e.y);
          end
          tests++;
          if (cyc != e.cyc) begin
            fails++;
            $display("FAIL done_latency got cycle %0d want %0d", cyc, e.cyc);
          end
`ifdef DECISION_SCORE_OUT_EN
          tests++;
          if (longint'(score) != e.f) begin
            fails++;
            $display("FAIL score got %0d want %0d", longint'(score), e.f);
          end
`endif
        end
      end
    end
  end

  task automatic check_idle_outputs(input string name);
    tests++;
    if (y_class !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL %s y_class/done got %0b/%0b want 0/0", name, y_class, done);
    end
`ifdef DECISION_SCORE_OUT_EN
    tests++;
    if (score !== '0) begin
      fails++;
      $display("FAIL %s score got %0d want 0", name, longint'(score));
    end
`endif
  endtask

  // One full decision: stall after term stall_at for stall_len cycles,
  // optionally hold the strobe high (with junk) during the finish cycle.
  task automatic run_case(input int stall_at, input int stall_len, input bit en_in_finish);
    exp_t   e;
    longint f;
    int     eff_stall;
    int     w;
    eff_stall = (stall_at >= 0 && stall_at < NSV-1) ? stall_len : 0;
    f = longint'(bias);
    for (int k = 0; k < NSV; k++) f += longint'(prod[k]) * longint'(kern[k]);
    for (int k = 0; k < NSV; k++) kernel_out[k*W +: W] = kern[k];
    b = bias;
    @(posedge clk); #1;
    e.y   = (f >= 0);
    e.f   = f;
    e.cyc = cyc + NSV + 1 + eff_stall;
    sb.push_back(e);
    for (int k = 0; k < NSV; k++) begin
      en = 1'b1;
      product = prod[k];
      @(posedge clk); #1;
      if (k == stall_at && k < NSV-1) begin
        for (int s = 0; s < stall_len; s++) begin
          en = 1'b0;
          product = W'($urandom);
          @(posedge clk); #1;
        end
      end
    end
    if (en_in_finish) begin
      en = 1'b1;
      product = W'($urandom);
      @(posedge clk); #1;
    end
    en = 1'b0;
    w = 0;
    while (sb.size() > 0 && w < 30) begin
      @(posedge clk); #1;
      w++;
    end
    if (sb.size() > 0) begin
      tests++; fails++;
      $display("FAIL done_timeout no done within 30 cycles, f=%0d", f);
      sb.delete();
    end
  endtask

  task automatic fill(input logic [W-1:0] kv, input logic [W-1:0] pv, input logic [W-1:0] bv);
    for (int k = 0; k < NSV; k++) begin
      kern[k] = kv;
      prod[k] = pv;
    end
    bias = bv;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_state");
    #1 rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset");

    // Case 1: f = 9
    fill(16'd1, 16'd1, 16'hFFFF);
    run_case(-1, 0, 1'b0);
    // Case 2: f = -15
    fill(16'd2, 16'hFFFF, 16'd5);
    run_case(-1, 0, 1'b0);
    // Case 3: f = 0 boundary
    fill(16'd1, 16'd1, 16'd0);
    for (int k = 5; k < NSV; k++) prod[k] = 16'hFFFF;
    run_case(-1, 0, 1'b0);
    // Case 4: case 1 with a 3-cycle stall after the 4th term
    fill(16'd1, 16'd1, 16'hFFFF);
    run_case(3, 3, 1'b0);

    // Case 5: abort after 6 terms, then case 2
    fill(16'd1, 16'd1, 16'hFFFF);
    run_case(-1, 0, 1'b0);
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      en = 1'b1;
      product = 16'd1;
      @(posedge clk); #1;
    end
    en = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_idle_outputs("abort_reset");
    rst = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    @(negedge clk);
    check_idle_outputs("abort_no_done");
    fill(16'd2, 16'hFFFF, 16'd5);
    run_case(-1, 0, 1'b0);

    // Case 6: extreme kernels
    fill(16'hFFFF, 16'h7FFF, 16'h7FFF);
    run_case(-1, 0, 1'b0);
    fill(16'hFFFF, 16'h8000, 16'h7FFF);
    run_case(-1, 0, 1'b1);

    // Randomised decisions with random stalls and strobes during FINISH
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < NSV; k++) begin
        kern[k] = W'($urandom);
        prod[k] = W'($urandom);
      end
      bias = W'($urandom);
      run_case($urandom_range(0, 14), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
